// File: rtl/csi_rx_pkt_decoder_pkg.sv
// Package csi_rx_pkg: shared types and constants for the CSI-2 receive packet decoder.
//   state_t       decoder FSM states
//   DT_*          CSI-2 data-type codes; DT_SHORT_MAX is the last short-packet code
//   CRC_INIT/POLY payload CRC-16 start value and reflected polynomial
//   csi_ecc6()    6-bit CSI-2 Hamming ECC over {WC_MSB, WC_LSB, DI}
package csi_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_CRC,
      ST_WAIT_END
   } state_t;

   localparam logic [5:0] DT_FS        = 6'h00;
   localparam logic [5:0] DT_FE        = 6'h01;
   localparam logic [5:0] DT_LS        = 6'h02;
   localparam logic [5:0] DT_LE        = 6'h03;
   localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h8408;

   // Each ECC bit is the parity of the header bits selected by its mask
   // (bit 0 of d is DI bit 0, bit 23 is WC MSB bit 7).
   function automatic logic [5:0] csi_ecc6(input logic [23:0] d);
      logic [5:0] e;
      e[0] = ^(d & 24'hF12CB7);
      e[1] = ^(d & 24'hF2555B);
      e[2] = ^(d & 24'h749A6D);
      e[3] = ^(d & 24'hB8E38E);
      e[4] = ^(d & 24'hDF03F0);
      e[5] = ^(d & 24'hEFFC00);
      return e;
   endfunction

endpackage

// File: rtl/csi_rx_pkt_decoder_if.sv
// Interface bundling the PPI receive byte stream and the decoder outputs.
//   rx_byte/rx_valid/rx_active/rx_sync   PPI HS receive signals (into the decoder)
//   out_data/out_valid/out_be/out_last   packed payload beats (from the decoder)
//   evt_valid/evt_vc/evt_dt/evt_data     short-packet events (from the decoder)
//   crc_err/pkt_err/ecc_err              one-cycle error pulses (from the decoder)
// Modports: master = PPI source / output sink side, slave = decoder side.
interface csi_rx_pkt_decoder_if #(
   parameter int P_DATA_WIDTH = 32
);
   logic [7:0]                rx_byte;
   logic                      rx_valid;
   logic                      rx_active;
   logic                      rx_sync;
   logic [P_DATA_WIDTH-1:0]   out_data;
   logic                      out_valid;
   logic [P_DATA_WIDTH/8-1:0] out_be;
   logic                      out_last;
   logic                      evt_valid;
   logic [1:0]                evt_vc;
   logic [5:0]                evt_dt;
   logic [15:0]               evt_data;
   logic                      crc_err;
   logic                      pkt_err;
   logic                      ecc_err;

   modport master (
      output rx_byte, rx_valid, rx_active, rx_sync,
      input  out_data, out_valid, out_be, out_last,
      input  evt_valid, evt_vc, evt_dt, evt_data,
      input  crc_err, pkt_err, ecc_err
   );

   modport slave (
      input  rx_byte, rx_valid, rx_active, rx_sync,
      output out_data, out_valid, out_be, out_last,
      output evt_valid, evt_vc, evt_dt, evt_data,
      output crc_err, pkt_err, ecc_err
   );
endinterface

// File: rtl/csi_rx_pkt_decoder_crc16.sv
// Byte-serial CRC-16 (reflected poly 0x8408, init 0xFFFF), one byte per enabled cycle.
//   clk, rst  clock and asynchronous active-high reset
//   clr       reload the init value (wins over en)
//   en        fold din into the running CRC
//   din       input byte, processed LSB first
//   crc       running CRC value, registered
module csi_rx_crc16
   import csi_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [15:0] crc
);

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc <= CRC_INIT;
      end else if (clr) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc16_byte(crc, din);
      end
   end

endmodule

// File: rtl/csi_rx_pkt_decoder.sv
// CSI-2 receive packet decoder for one D-PHY lane, clocked by the byte clock.
// Parses the 4-byte header, emits short packets as events, packs long-packet
// payload LSB-first into P_DATA_WIDTH words and checks the payload CRC-16.
//   hs_clk  byte clock
//   rst     asynchronous active-high reset
//   bus     csi_rx_pkt_decoder_if.slave (PPI inputs, beat/event/error outputs)
// Build option: define CSI_RX_ECC_CHECK_EN to check the header ECC and report
// mismatches on ecc_err; otherwise the ECC byte is skipped and ecc_err is 0.
module csi_rx_pkt_decoder
   import csi_rx_pkg::*;
#(
   parameter int P_DATA_WIDTH = 32,
   parameter int P_WC_WIDTH   = 16
) (
   input  logic                  hs_clk,
   input  logic                  rst,
   csi_rx_pkt_decoder_if.slave   bus
);

   localparam int NB    = P_DATA_WIDTH / 8;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

   state_t                  state_q;
   logic [1:0]              cnt_q;
   logic [7:0]              di_q;
   logic [15:0]             wc16_q;
   logic [7:0]              crc_lo_q;
   logic [P_WC_WIDTH-1:0]   rem_q;
   logic [P_DATA_WIDTH-1:0] pack_q;
   logic [IDX_W-1:0]        idx_q;

   logic [P_DATA_WIDTH-1:0] out_data_q;
   logic [NB-1:0]           out_be_q;
   logic                    out_valid_q, out_last_q;
   logic                    evt_valid_q;
   logic [1:0]              evt_vc_q;
   logic [5:0]              evt_dt_q;
   logic [15:0]             evt_data_q;
   logic                    crc_err_q, pkt_err_q;

   logic [P_DATA_WIDTH-1:0] word_nxt;
   logic [NB-1:0]           be_nxt;
   logic [P_WC_WIDTH-1:0]   wc_len;
   logic                    last_byte, word_done, hdr_ecc_ok;
   logic [15:0]             crc_val;
   logic                    crc_clr, crc_en;

   assign wc_len    = P_WC_WIDTH'(wc16_q);
   assign last_byte = (rem_q == P_WC_WIDTH'(1));
   assign word_done = last_byte || (idx_q == IDX_W'(NB - 1));

   // Current word with the incoming byte dropped into its lane.
   always_comb begin
      word_nxt = pack_q;
      be_nxt   = '0;
      for (int i = 0; i < NB; i++) begin
         if (idx_q == IDX_W'(i)) word_nxt[i*8 +: 8] = bus.rx_byte;
         be_nxt[i] = (IDX_W'(i) <= idx_q);
      end
   end

`ifdef CSI_RX_ECC_CHECK_EN
   logic ecc_err_q;
   assign hdr_ecc_ok  = (csi_ecc6({wc16_q, di_q}) == bus.rx_byte[5:0]);
   assign bus.ecc_err = ecc_err_q;
`else
   assign hdr_ecc_ok  = 1'b1;
   assign bus.ecc_err = 1'b0;
`endif

   // CRC restarts while idle so every long packet begins from the init value.
   assign crc_clr = (state_q == ST_IDLE);
   assign crc_en  = (state_q == ST_PAYLOAD) && bus.rx_valid && bus.rx_active;

   csi_rx_crc16 u_crc (
      .clk (hs_clk),
      .rst (rst),
      .clr (crc_clr),
      .en  (crc_en),
      .din (bus.rx_byte),
      .crc (crc_val)
   );

   always_ff @(posedge hs_clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         di_q        <= '0;
         wc16_q      <= '0;
         crc_lo_q    <= '0;
         rem_q       <= '0;
         pack_q      <= '0;
         idx_q       <= '0;
         out_data_q  <= '0;
         out_be_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_vc_q    <= '0;
         evt_dt_q    <= '0;
         evt_data_q  <= '0;
         crc_err_q   <= 1'b0;
         pkt_err_q   <= 1'b0;
`ifdef CSI_RX_ECC_CHECK_EN
         ecc_err_q   <= 1'b0;
`endif
      end else begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         evt_valid_q <= 1'b0;
         crc_err_q   <= 1'b0;
         pkt_err_q   <= 1'b0;
`ifdef CSI_RX_ECC_CHECK_EN
         ecc_err_q   <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (bus.rx_sync && bus.rx_valid && bus.rx_active) begin
                  di_q    <= bus.rx_byte;
                  cnt_q   <= '0;
                  state_q <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (!bus.rx_active) begin
                  pkt_err_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else if (bus.rx_valid) begin
                  case (cnt_q)
                     2'd0: begin
                        wc16_q[7:0] <= bus.rx_byte;
                        cnt_q       <= 2'd1;
                     end
                     2'd1: begin
                        wc16_q[15:8] <= bus.rx_byte;
                        cnt_q        <= 2'd2;
                     end
                     default: begin
                        // ECC byte: header complete, pick the packet kind.
                        cnt_q  <= '0;
                        pack_q <= '0;
                        idx_q  <= '0;
                        rem_q  <= wc_len;
                        if (!hdr_ecc_ok) begin
`ifdef CSI_RX_ECC_CHECK_EN
                           ecc_err_q <= 1'b1;
`endif
                           state_q <= ST_WAIT_END;
                        end else if (di_q[5:0] <= DT_SHORT_MAX) begin
                           evt_valid_q <= 1'b1;
                           evt_vc_q    <= di_q[7:6];
                           evt_dt_q    <= di_q[5:0];
                           evt_data_q  <= wc16_q;
                           state_q     <= ST_WAIT_END;
                        end else if (wc_len == '0) begin
                           state_q <= ST_CRC;
                        end else begin
                           state_q <= ST_PAYLOAD;
                        end
                     end
                  endcase
               end
            end
            ST_PAYLOAD: begin
               if (!bus.rx_active) begin
                  // Truncated: the partially filled word is dropped.
                  pkt_err_q <= 1'b1;
                  pack_q    <= '0;
                  idx_q     <= '0;
                  state_q   <= ST_IDLE;
               end else if (bus.rx_valid) begin
                  rem_q <= rem_q - P_WC_WIDTH'(1);
                  if (word_done) begin
                     out_data_q  <= word_nxt;
                     out_be_q    <= be_nxt;
                     out_valid_q <= 1'b1;
                     out_last_q  <= last_byte;
                     pack_q      <= '0;
                     idx_q       <= '0;
                  end else begin
                     pack_q <= word_nxt;
                     idx_q  <= idx_q + IDX_W'(1);
                  end
                  if (last_byte) state_q <= ST_CRC;
               end
            end
            ST_CRC: begin
               if (!bus.rx_active) begin
                  pkt_err_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= ST_IDLE;
               end else if (bus.rx_valid) begin
                  if (cnt_q == 2'd0) begin
                     crc_lo_q <= bus.rx_byte;
                     cnt_q    <= 2'd1;
                  end else begin
                     crc_err_q <= ({bus.rx_byte, crc_lo_q} != crc_val);
                     cnt_q     <= '0;
                     state_q   <= ST_WAIT_END;
                  end
               end
            end
            ST_WAIT_END: begin
               if (!bus.rx_active) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_be    = out_be_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.evt_valid = evt_valid_q;
   assign bus.evt_vc    = evt_vc_q;
   assign bus.evt_dt    = evt_dt_q;
   assign bus.evt_data  = evt_data_q;
   assign bus.crc_err   = crc_err_q;
   assign bus.pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_csi_rx_pkt_decoder.sv
// Self-checking bench for csi_rx_pkt_decoder: directed cases followed by random
// bursts, checked every cycle against a packet-level model of the decoder.
`timescale 1ns/1ps
module tb_csi_rx_pkt_decoder;

   localparam int DW = 32;
   localparam int NB = DW / 8;

   typedef struct {
      logic [DW-1:0] data;
      logic [NB-1:0] be;
      logic          last;
   } beat_t;

   typedef struct {
      logic [1:0]  vc;
      logic [5:0]  dt;
      logic [15:0] data;
   } evt_t;

   logic hs_clk = 1'b0;
   logic rst;
   always #5 hs_clk = ~hs_clk;

   csi_rx_pkt_decoder_if #(.P_DATA_WIDTH(DW)) bus ();

   csi_rx_pkt_decoder #(.P_DATA_WIDTH(DW), .P_WC_WIDTH(16)) dut (
      .hs_clk (hs_clk),
      .rst    (rst),
      .bus    (bus)
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t exp_beats[$];
   evt_t  exp_evts[$];
   int    exp_crc_err = 0;
   int    exp_pkt_err = 0;
   int    exp_ecc_err = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] crc_model(input logic [7:0] b[$], input int off, input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ b[off+i][j];
            c  = {1'b0, c[15:1]};
            if (fb) c = c ^ 16'h8408;
         end
      end
      return c;
   endfunction

   function automatic logic [5:0] ecc_model(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return p;
   endfunction

   // Builds header (+ payload + CRC for long DTs); flip corrupts DI after the ECC is computed.
   task automatic build_pkt(output logic [7:0] q[$], input logic [1:0] vc, input logic [5:0] dt,
                            input logic [15:0] wc, input logic [7:0] pay[$],
                            input logic [15:0] crcx, input logic [7:0] flip);
      logic [7:0]  di;
      logic [15:0] c;
      di = {vc, dt};
      q  = {};
      q.push_back(di ^ flip);
      q.push_back(wc[7:0]);
      q.push_back(wc[15:8]);
      q.push_back({2'b00, ecc_model({wc, di})});
      if (dt >= 6'h10) begin
         foreach (pay[i]) q.push_back(pay[i]);
         c = crc_model(pay, 0, pay.size()) ^ crcx;
         q.push_back(c[7:0]);
         q.push_back(c[15:8]);
      end
   endtask

   // Expected outputs when the first k bytes of pkt arrive before rx_active falls.
   task automatic model_packet(input logic [7:0] pkt[$], input int k);
      logic [7:0]  di;
      int          wc, npay, e;
      evt_t        ev;
      beat_t       b;
      logic [15:0] c;
      if (k < 4) begin
         exp_pkt_err++;
         return;
      end
      di = pkt[0];
      wc = {pkt[2], pkt[1]};
`ifdef CSI_RX_ECC_CHECK_EN
      if (ecc_model({pkt[2], pkt[1], pkt[0]}) != pkt[3][5:0]) begin
         exp_ecc_err++;
         return;
      end
`endif
      if (di[5:0] < 6'h10) begin
         ev.vc = di[7:6]; ev.dt = di[5:0]; ev.data = wc[15:0];
         exp_evts.push_back(ev);
         return;
      end
      npay = (k - 4 < wc) ? k - 4 : wc;
      for (int s = 0; s < wc; s += NB) begin
         e = (s + NB < wc) ? s + NB : wc;
         if (e <= npay) begin
            b.data = '0;
            b.be   = '0;
            for (int j = 0; j < e - s; j++) begin
               b.data[8*j +: 8] = pkt[4+s+j];
               b.be[j]          = 1'b1;
            end
            b.last = (e == wc);
            exp_beats.push_back(b);
         end
      end
      if (k < 4 + wc + 2) begin
         exp_pkt_err++;
         return;
      end
      c = crc_model(pkt, 4, wc);
      if ({pkt[4+wc+1], pkt[4+wc]} != c) exp_crc_err++;
   endtask

   // ---------------- stimulus ----------------
   // mode 0: no gaps, 1: rx_valid low every other cycle, 2: random gaps
   task automatic send_bytes(input logic [7:0] pkt[$], input int k, input int mode);
      int i, cyc;
      i = 0; cyc = 0;
      while (i < k) begin
         @(posedge hs_clk); #1;
         bus.rx_active = 1'b1;
         if (i > 0 && ((mode == 1 && cyc[0]) || (mode == 2 && $urandom_range(0, 2) == 0))) begin
            bus.rx_valid = 1'b0;
            bus.rx_sync  = 1'($urandom);
            bus.rx_byte  = 8'($urandom);
         end else begin
            bus.rx_valid = 1'b1;
            bus.rx_sync  = (i == 0) ? 1'b1 : 1'($urandom);
            bus.rx_byte  = pkt[i];
            i++;
         end
         cyc++;
      end
   endtask

   task automatic drain_check();
      @(negedge hs_clk);
      check("beats_missing",   exp_beats.size(), 0);
      check("events_missing",  exp_evts.size(),  0);
      check("crc_err_missing", exp_crc_err, 0);
      check("pkt_err_missing", exp_pkt_err, 0);
      check("ecc_err_missing", exp_ecc_err, 0);
      exp_beats = {}; exp_evts = {};
      exp_crc_err = 0; exp_pkt_err = 0; exp_ecc_err = 0;
   endtask

   task automatic send_burst(input logic [7:0] pkt[$], input int k, input int mode, input int extra);
      send_bytes(pkt, k, mode);
      if (k == pkt.size()) begin
         for (int e = 0; e < extra; e++) begin
            @(posedge hs_clk); #1;
            bus.rx_valid = 1'b1;
            bus.rx_sync  = 1'($urandom);
            bus.rx_byte  = 8'($urandom);
         end
      end
      @(posedge hs_clk); #1;
      bus.rx_active = 1'b0;
      bus.rx_valid  = 1'b0;
      bus.rx_sync   = 1'b0;
      repeat (3) @(posedge hs_clk);
      drain_check();
   endtask

   task automatic run_pkt(input logic [7:0] pkt[$], input int k, input int mode, input int extra);
      model_packet(pkt, k);
      send_burst(pkt, k, mode, extra);
   endtask

   // ---------------- per-cycle compare ----------------
   task automatic pulse_chk(input string nm, input logic p, inout int pend);
      if (p) begin
         n_checks++;
         if (pend > 0) pend--;
         else begin
            n_fail++;
            $display("FAIL %s: got an unexpected pulse, required none", nm);
         end
      end
   endtask

   task automatic monitor();
      beat_t b;
      evt_t  ev;
      forever begin
         @(negedge hs_clk);
         if (!rst) begin
            if (bus.out_valid) begin
               if (exp_beats.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL beat_unexpected: got data=%0h be=%0h, required no beat", bus.out_data, bus.out_be);
               end else begin
                  b = exp_beats.pop_front();
                  check("beat_data", bus.out_data, b.data);
                  check("beat_be",   bus.out_be,   b.be);
                  check("beat_last", bus.out_last, b.last);
               end
            end else if (bus.out_last) begin
               check("last_without_valid", bus.out_last, 1'b0);
            end
            if (bus.evt_valid) begin
               if (exp_evts.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL evt_unexpected: got dt=%0h data=%0h, required no event", bus.evt_dt, bus.evt_data);
               end else begin
                  ev = exp_evts.pop_front();
                  check("evt_vc",   bus.evt_vc,   ev.vc);
                  check("evt_dt",   bus.evt_dt,   ev.dt);
                  check("evt_data", bus.evt_data, ev.data);
               end
            end
            pulse_chk("crc_err", bus.crc_err, exp_crc_err);
            pulse_chk("pkt_err", bus.pkt_err, exp_pkt_err);
            pulse_chk("ecc_err", bus.ecc_err, exp_ecc_err);
         end
      end
   endtask

   // ---------------- main ----------------
   initial begin
      logic [7:0]  pkt[$];
      logic [7:0]  pay[$];
      logic [7:0]  q9[$];
      logic [1:0]  vc;
      logic [5:0]  dt;
      logic [15:0] wc, crcx;
      logic [7:0]  flip;
      int          k, mode, extra;

      rst = 1'b1;
      bus.rx_byte = '0; bus.rx_valid = 1'b0; bus.rx_active = 1'b0; bus.rx_sync = 1'b0;
      repeat (3) @(posedge hs_clk);
      #1 rst = 1'b0;
      @(negedge hs_clk);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data",  bus.out_data,  '0);
      check("rst_out_be_last", {bus.out_be, bus.out_last}, '0);
      check("rst_evt_valid", bus.evt_valid, 1'b0);
      check("rst_evt_fields", {bus.evt_vc, bus.evt_dt, bus.evt_data}, '0);
      check("rst_errs", {bus.crc_err, bus.pkt_err, bus.ecc_err}, '0);

      fork monitor(); join_none

      // Model pins: published CRC check value and a hand-worked ECC.
      q9 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      check("model_crc_check", crc_model(q9, 0, 9), 16'h6F91);
      check("model_ecc_hdr",   ecc_model(24'h000100), 6'h1A);

      // 1: short FS, frame number 1
      pay = {};
      build_pkt(pkt, 2'd0, 6'h00, 16'h0001, pay, 16'h0, 8'h0);
      check("t1_bytes", {pkt[0], pkt[1], pkt[2], pkt[3]}, 32'h0001_001A);
      model_packet(pkt, pkt.size());
      check("t1_model_evt", {exp_evts[0].vc, exp_evts[0].dt, exp_evts[0].data}, 24'h00_0001);
      send_burst(pkt, pkt.size(), 0, 2);

      // 2: long DT 0x2A, WC 6, good CRC
      pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      build_pkt(pkt, 2'd0, 6'h2A, 16'd6, pay, 16'h0, 8'h0);
      model_packet(pkt, pkt.size());
      check("t2_model_b0", {exp_beats[0].data, exp_beats[0].be, 3'b0, exp_beats[0].last}, {32'h44332211, 4'hF, 4'h0});
      check("t2_model_b1", {exp_beats[1].data, exp_beats[1].be, 3'b0, exp_beats[1].last}, {32'h00006655, 4'h3, 4'h1});
      check("t2_model_crc", exp_crc_err, 0);
      send_burst(pkt, pkt.size(), 0, 1);

      // 3: same with CRC LSB corrupted
      build_pkt(pkt, 2'd0, 6'h2A, 16'd6, pay, 16'h0001, 8'h0);
      model_packet(pkt, pkt.size());
      check("t3_model_crc", exp_crc_err, 1);
      send_burst(pkt, pkt.size(), 0, 0);

      // 4: WC 8 truncated after 3 payload bytes, then an FE in the next burst
      pay = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
      build_pkt(pkt, 2'd1, 6'h2B, 16'd8, pay, 16'h0, 8'h0);
      model_packet(pkt, 7);
      check("t4_model_pkt", exp_pkt_err, 1);
      send_burst(pkt, 7, 0, 0);
      pay = {};
      build_pkt(pkt, 2'd1, 6'h01, 16'h0007, pay, 16'h0, 8'h0);
      run_pkt(pkt, pkt.size(), 0, 0);

      // 5: case 2 with alternating gaps, then WC 0 long packet with CRC FFFF
      pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      build_pkt(pkt, 2'd0, 6'h2A, 16'd6, pay, 16'h0, 8'h0);
      run_pkt(pkt, pkt.size(), 1, 0);
      pay = {};
      build_pkt(pkt, 2'd2, 6'h24, 16'd0, pay, 16'h0, 8'h0);
      check("t5_wc0_crc_bytes", {pkt[5], pkt[4]}, 16'hFFFF);
      run_pkt(pkt, pkt.size(), 1, 0);

      // 6: DI bit flipped after ECC (LS becomes LE)
      build_pkt(pkt, 2'd0, 6'h02, 16'h0123, pay, 16'h0, 8'h01);
      model_packet(pkt, pkt.size());
`ifdef CSI_RX_ECC_CHECK_EN
      check("t6_model_ecc", exp_ecc_err, 1);
`else
      check("t6_model_dt", exp_evts[0].dt, 6'h03);
`endif
      send_burst(pkt, pkt.size(), 0, 0);

      // Reset in the middle of a payload: nothing from that packet may appear.
      pay = {};
      for (int i = 0; i < 10; i++) pay.push_back(8'($urandom));
      build_pkt(pkt, 2'd0, 6'h30, 16'd10, pay, 16'h0, 8'h0);
      send_bytes(pkt, 7, 0);
      #2;
      rst = 1'b1;
      bus.rx_valid = 1'b0; bus.rx_active = 1'b0; bus.rx_sync = 1'b0;
      #1;
      check("async_rst_outputs", {bus.out_valid, bus.evt_valid, bus.crc_err, bus.pkt_err, bus.out_be}, '0);
      repeat (2) @(posedge hs_clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge hs_clk);
      drain_check();

      // Random traffic
      for (int n = 0; n < 200; n++) begin
         vc = 2'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            dt = 6'($urandom_range(16, 63));
            wc = 16'($urandom_range(0, 13));
         end else begin
            dt = 6'($urandom_range(0, 15));
            wc = 16'($urandom);
         end
         pay = {};
         if (dt >= 6'h10) for (int i = 0; i < int'(wc); i++) pay.push_back(8'($urandom));
         crcx  = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
         flip  = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0;
         build_pkt(pkt, vc, dt, wc, pay, crcx, flip);
         k = pkt.size();
         if ($urandom_range(0, 6) == 0) k = $urandom_range(1, pkt.size() - 1);
         mode  = ($urandom_range(0, 1) == 1) ? 2 : 0;
         extra = $urandom_range(0, 3);
         run_pkt(pkt, k, mode, extra);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
